// File: rtl/divu_if.sv
// divu_if: handshake and operand/result bundle between the core control and the
// multi-cycle unsigned divider.
//   start        request to divide (core -> divider)
//   dividend     rs operand (core -> divider)
//   divisor      rt operand (core -> divider)
//   busy         divider iterating; core stalls PC (divider -> core)
//   done         one-cycle result strobe (divider -> core)
//   div_by_zero  captured divisor was zero, valid with done (divider -> core)
//   quotient     result for LO (divider -> core)
//   remainder    result for HI (divider -> core)
interface divu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;

  modport master (
    output start, dividend, divisor,
    input  busy, done, div_by_zero, quotient, remainder
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, div_by_zero, quotient, remainder
  );
endinterface

// File: rtl/divu_seq.sv
// divu_seq: multi-cycle restoring unsigned divider (MIPS DIVU), one quotient bit
// per clock. Quotient feeds LO, remainder feeds HI; busy stalls the core.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous reset, active-high; aborts any division in flight
//   bus   divu_if slave modport: start/dividend/divisor in,
//         busy/done/div_by_zero/quotient/remainder out
// A divisor of zero short-circuits straight to DONE with quotient all ones and
// remainder equal to the dividend.
module divu_seq #(
  parameter int WIDTH = 32
) (
  input  logic   clk,
  input  logic   rst,
  divu_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH:0]     rem_q, rem_d;    // partial remainder, one guard bit
  logic [WIDTH-1:0]   acc_q, acc_d;    // dividend shifting out / quotient shifting in
  logic [WIDTH-1:0]   dvsr_q, dvsr_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   rmd_q, rmd_d;
  logic               dbz_q, dbz_d;

  logic [WIDTH:0]     step_r;
  logic [WIDTH-1:0]   step_q;

  // One restoring iteration: shift the next dividend bit into the remainder,
  // subtract the divisor if it fits and record the quotient bit.
  function automatic logic [2*WIDTH:0] restore_step(
    input logic [WIDTH:0]   r,
    input logic [WIDTH-1:0] q,
    input logic [WIDTH-1:0] d
  );
    logic [WIDTH:0]   r_sh;
    logic [WIDTH-1:0] q_sh;
    r_sh = {r[WIDTH-1:0], q[WIDTH-1]};
    q_sh = {q[WIDTH-2:0], 1'b0};
    if (r_sh >= {1'b0, d}) begin
      r_sh    = r_sh - {1'b0, d};
      q_sh[0] = 1'b1;
    end
    return {r_sh, q_sh};
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    acc_d   = acc_q;
    dvsr_d  = dvsr_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    dbz_d   = dbz_q;
    {step_r, step_q} = restore_step(rem_q, acc_q, dvsr_q);

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (bus.start) begin
          if (bus.divisor != '0) begin
            state_d = S_RUN;
            acc_d   = bus.dividend;
            dvsr_d  = bus.divisor;
            rem_d   = '0;
            cnt_d   = '0;
            dbz_d   = 1'b0;
          end else begin
            state_d = S_DONE;
            quo_d   = '1;
            rmd_d   = bus.dividend;
            dbz_d   = 1'b1;
          end
        end
      end
      S_RUN: begin
        rem_d = step_r;
        acc_d = step_q;
        cnt_d = cnt_q + 1'b1;
        // Final step: publish the result as we enter DONE. The remainder is
        // always below the divisor, so the guard bit is zero here.
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = S_DONE;
          quo_d   = step_q;
          rmd_d   = step_r[WIDTH-1:0];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      quo_q   <= '0;
      rmd_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      dbz_q   <= dbz_d;
    end
  end

  // Working registers are always reloaded on acceptance, so they need no reset.
  always_ff @(posedge clk) begin
    rem_q  <= rem_d;
    acc_q  <= acc_d;
    dvsr_q <= dvsr_d;
  end

  assign bus.busy        = (state_q == S_RUN);
  assign bus.done        = (state_q == S_DONE);
  assign bus.div_by_zero = dbz_q;
  assign bus.quotient    = quo_q;
  assign bus.remainder   = rmd_q;

endmodule

// File: tb/tb_divu_seq.sv
module tb_divu_seq;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  int   passes = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  divu_if #(.WIDTH(W)) bus ();

  divu_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Present operands with start for one edge, then drop start.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    tick();
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
  endtask

  // Called right after the accepting edge. Counts cycles until done, counting
  // busy cycles on the way; optionally pokes a stray start at RUN cycle 'poke'.
  task automatic wait_done(input string tag, input int exp_lat, input int poke);
    int n;
    int nb;
    n  = 0;
    nb = 0;
    while (bus.done !== 1'b1 && n < 40) begin
      if (bus.busy === 1'b1) nb++;
      if (n == poke) begin
        bus.start    = 1'b1;
        bus.dividend = 32'd50;
        bus.divisor  = 32'd5;
      end
      tick();
      bus.start = 1'b0;
      n++;
    end
    chk({tag, ".latency"}, 64'(n), 64'(exp_lat));
    chk({tag, ".busy_cycles"}, 64'(nb), 64'(exp_lat));
    chk({tag, ".done"}, 64'(bus.done), 64'd1);
    chk({tag, ".busy_at_done"}, 64'(bus.busy), 64'd0);
  endtask

  task automatic chk_res(input string tag, input logic [W-1:0] q, input logic [W-1:0] r,
                         input logic dbz);
    chk({tag, ".q"}, 64'(bus.quotient), 64'(q));
    chk({tag, ".r"}, 64'(bus.remainder), 64'(r));
    chk({tag, ".dbz"}, 64'(bus.div_by_zero), 64'(dbz));
  endtask

  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           seen;

    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    tick();
    tick();
    chk("reset.busy", 64'(bus.busy), 64'd0);
    chk("reset.done", 64'(bus.done), 64'd0);
    chk_res("reset", 32'd0, 32'd0, 1'b0);
    rst = 1'b0;
    tick();

    // 100 / 7
    issue(32'd100, 32'd7);
    chk("t1.busy_after_accept", 64'(bus.busy), 64'd1);
    wait_done("t1", 32, -1);
    chk_res("t1", 32'd14, 32'd2, 1'b0);
    tick();
    chk("t1.done_one_cycle", 64'(bus.done), 64'd0);
    chk_res("t1.held", 32'd14, 32'd2, 1'b0);

    // Extremes
    issue(32'hFFFF_FFFF, 32'd1);
    wait_done("t2a", 32, -1);
    chk_res("t2a", 32'hFFFF_FFFF, 32'd0, 1'b0);
    tick();
    issue(32'hFFFF_FFFF, 32'h8000_0000);
    wait_done("t2b", 32, -1);
    chk_res("t2b", 32'd1, 32'h7FFF_FFFF, 1'b0);
    tick();

    // Divide by zero: done right after the start edge, busy never set
    issue(32'd5, 32'd0);
    wait_done("t3", 0, -1);
    chk_res("t3", 32'hFFFF_FFFF, 32'd5, 1'b1);
    tick();
    chk("t3.done_one_cycle", 64'(bus.done), 64'd0);
    chk("t3.dbz_held", 64'(bus.div_by_zero), 64'd1);

    // dividend < divisor, stray start mid-RUN ignored; dbz clears on acceptance
    issue(32'd3, 32'd10);
    chk("t4.dbz_cleared", 64'(bus.div_by_zero), 64'd0);
    chk("t4.q_held_in_run", 64'(bus.quotient), 64'hFFFF_FFFF);
    wait_done("t4", 32, 10);
    chk_res("t4", 32'd0, 32'd3, 1'b0);

    // Back-to-back: start held during DONE
    bus.start    = 1'b1;
    bus.dividend = 32'd81;
    bus.divisor  = 32'd9;
    chk_res("t5.run1_in_done", 32'd0, 32'd3, 1'b0);
    tick();
    bus.start = 1'b0;
    chk("t5.no_idle_gap", 64'(bus.busy), 64'd1);
    chk_res("t5.run1_held", 32'd0, 32'd3, 1'b0);
    wait_done("t5", 32, -1);
    chk_res("t5", 32'd9, 32'd0, 1'b0);
    tick();

    // Equal operands and zero dividend
    issue(32'd12345, 32'd12345);
    wait_done("t7a", 32, -1);
    chk_res("t7a", 32'd1, 32'd0, 1'b0);
    issue(32'd0, 32'd5);
    wait_done("t7b", 32, -1);
    chk_res("t7b", 32'd0, 32'd0, 1'b0);
    tick();

    // Reset mid-RUN
    issue(32'd1000, 32'd3);
    for (int i = 0; i < 15; i++) tick();
    chk("t6.busy_before_rst", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6.busy", 64'(bus.busy), 64'd0);
    chk("t6.done", 64'(bus.done), 64'd0);
    chk_res("t6", 32'd0, 32'd0, 1'b0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
      tick();
    end
    chk("t6.no_done_after_abort", 64'(seen), 64'd0);

    // Random pairs checked against the division identity
    for (int i = 0; i < 1000; i++) begin
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      if (b == '0) b = 32'd1;
      issue(a, b);
      wait_done("rnd", 32, -1);
      chk("rnd.identity", 64'(bus.quotient) * 64'(b) + 64'(bus.remainder), 64'(a));
      chk("rnd.r_lt_d", 64'(bus.remainder < b), 64'd1);
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
